// File: rtl/thermal_pkg.sv
// Shared state encoding and default timing constants for the thermal shutdown controller.
package thermal_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_WARN_TIMEOUT    = 16;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 32;
  localparam int unsigned DEF_CNT_W           = 8;

  localparam int unsigned STATE_W = 2;

  // ST_ILLEGAL is never entered by design; it exists so the fail-safe decode is explicit.
  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 2'd0,
    ST_WARN    = 2'd1,
    ST_OFF     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/thermal_shutdown_ctrl_level_debounce.sv
// Level debouncer: output follows the input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module level_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else if (din == r_dout) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_dout <= din;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/thermal_shutdown_ctrl.sv
// CPU thermal protection sequencer: debounced overheat -> throttle/warn -> forced power-off,
// with release only after a full cool-down and a power-button press.
module thermal_shutdown_ctrl
  import thermal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WARN_TIMEOUT    = DEF_WARN_TIMEOUT,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_overheated,
  input  logic               sw_ack,
  input  logic               power_button,
  output logic               throttle,
  output logic               warn_irq,
  output logic               shut_off_computer,
  output logic               cool_ready,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(WARN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COOL_MAX  = CNT_W'(COOLDOWN_CYCLES);

  logic             w_overheat_f;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_warn_cnt;
  logic [CNT_W-1:0] w_warn_cnt_nxt;
  logic [CNT_W-1:0] r_cool_cnt;
  logic [CNT_W-1:0] w_cool_cnt_nxt;
  logic             r_throttle;
  logic             r_warn_irq;
  logic             r_shut_off;
  logic             r_cool_ready;

  level_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_overheat_deb (
    .clk   (clk),
    .reset (reset),
    .din   (cpu_overheated),
    .dout  (w_overheat_f)
  );

  // Next-state and counter updates; the illegal encoding falls into OFF as the safe state.
  always_comb begin
    w_state_nxt    = r_state;
    w_warn_cnt_nxt = r_warn_cnt;
    w_cool_cnt_nxt = r_cool_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_overheat_f) begin
          w_state_nxt    = ST_WARN;
          w_warn_cnt_nxt = '0;
        end
      end
      ST_WARN: begin
        if (sw_ack || (r_warn_cnt == WARN_LAST)) begin
          w_state_nxt    = ST_OFF;
          w_cool_cnt_nxt = '0;
        end else if (!w_overheat_f) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_warn_cnt_nxt = r_warn_cnt + CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (power_button && (r_cool_cnt == COOL_MAX)) begin
          w_state_nxt = ST_RUN;
        end else if (w_overheat_f) begin
          w_cool_cnt_nxt = '0;
        end else if (r_cool_cnt != COOL_MAX) begin
          w_cool_cnt_nxt = r_cool_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_OFF;
        w_cool_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are registered alongside the state so none of them see an input combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_warn_cnt   <= '0;
      r_cool_cnt   <= '0;
      r_throttle   <= 1'b0;
      r_warn_irq   <= 1'b0;
      r_shut_off   <= 1'b0;
      r_cool_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_warn_cnt   <= w_warn_cnt_nxt;
      r_cool_cnt   <= w_cool_cnt_nxt;
      r_throttle   <= (w_state_nxt == ST_WARN);
      r_warn_irq   <= (w_state_nxt == ST_WARN) && (r_state != ST_WARN);
      r_shut_off   <= (w_state_nxt == ST_OFF);
      r_cool_ready <= (w_state_nxt == ST_OFF) && (w_cool_cnt_nxt == COOL_MAX);
    end
  end

  assign throttle          = r_throttle;
  assign warn_irq          = r_warn_irq;
  assign shut_off_computer = r_shut_off;
  assign cool_ready        = r_cool_ready;
  assign state_o           = r_state;

endmodule
